// File: rtl/pselect.sv
// Rotating-priority selector: grants the first set request found from a
// sel-controlled start position, with a registered copy of the grant.
module pselect #(
  parameter int N   = 8,
  parameter int DIR = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] sel,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic [N-1:0]         gnt_q,
  output logic                 gnt_valid_q
);

  localparam int W = $clog2(N);

  // Walk positions from the start point, wrapping modulo N; DIR=1 mirrors the start and walks downward.
  always_comb begin
    int   startPos;
    int   idx;
    logic found;
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    idx      = 0;
    startPos = (int'(sel) >= N) ? 0 : int'(sel);
    if (DIR != 0) begin
      startPos = N - 1 - startPos;
    end
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (DIR == 0) begin
          idx = (startPos + k) % N;
        end else begin
          idx = (startPos - k + N) % N;
        end
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = W'(idx);
        end
      end
    end
  end

  assign gnt_valid = |gnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      gnt_q       <= gnt;
      gnt_valid_q <= gnt_valid;
    end
  end

endmodule

// File: tb/tb_pselect.sv
// Bench for pselect: N=8 in both directions plus N=5 for out-of-range sel,
// checked against a rotate-and-isolate reference model.
module tb_pselect;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       en;
  logic [2:0] sel;

  logic [7:0] g0, gq0, g1, gq1;
  logic [2:0] i0, i1, i5;
  logic       v0, vq0, v1, vq1, v5, vq5;
  logic [4:0] g5, gq5;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pselect #(.N(8), .DIR(0)) dut0 (
    .clock(clock), .reset(reset), .req(req), .en(en), .sel(sel),
    .gnt(g0), .gnt_idx(i0), .gnt_valid(v0), .gnt_q(gq0), .gnt_valid_q(vq0)
  );

  pselect #(.N(8), .DIR(1)) dut1 (
    .clock(clock), .reset(reset), .req(req), .en(en), .sel(sel),
    .gnt(g1), .gnt_idx(i1), .gnt_valid(v1), .gnt_q(gq1), .gnt_valid_q(vq1)
  );

  pselect #(.N(5), .DIR(0)) dut5 (
    .clock(clock), .reset(reset), .req(req[4:0]), .en(en), .sel(sel),
    .gnt(g5), .gnt_idx(i5), .gnt_valid(v5), .gnt_q(gq5), .gnt_valid_q(vq5)
  );

  // Mirror for DIR=1, rotate a doubled vector by the start offset, then isolate the lowest set bit.
  function automatic int modelIdx(input int n, input int dir, input logic [7:0] r, input int s, input logic e);
    logic [15:0] dbl, rot, iso;
    logic [7:0]  v;
    int          off;
    v = '0;
    if (!e) return -1;
    if (s >= n) s = 0;
    for (int i = 0; i < n; i++) v[(dir != 0) ? n - 1 - i : i] = r[i];
    dbl = 16'(v) | (16'(v) << n);
    rot = (dbl >> s) & 16'((1 << n) - 1);
    if (rot == 16'd0) return -1;
    iso = rot & (~rot + 16'd1);
    off = ($clog2(iso) + s) % n;
    return (dir != 0) ? n - 1 - off : off;
  endfunction

  function automatic logic [7:0] gVec(input int ix);
    return (ix < 0) ? 8'd0 : 8'(1 << ix);
  endfunction

  function automatic logic [31:0] combExp(input int n, input int dir, input logic [7:0] r, input int s, input logic e);
    int ix;
    ix = modelIdx(n, dir, r, s, e);
    return {20'd0, gVec(ix), (ix < 0) ? 3'd0 : 3'(ix), ix >= 0};
  endfunction

  function automatic logic [31:0] regExp(input int n, input int dir, input logic [7:0] r, input int s, input logic e);
    int ix;
    ix = modelIdx(n, dir, r, s, e);
    return {23'd0, gVec(ix), ix >= 0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic e, input logic [2:0] s);
    req = r;
    en  = e;
    sel = s;
    #1;
  endtask

  task automatic checkComb(input string tag);
    checkOutput({tag, "_d0"}, {20'd0, g0, i0, v0}, combExp(8, 0, req, int'(sel), en));
    checkOutput({tag, "_d1"}, {20'd0, g1, i1, v1}, combExp(8, 1, req, int'(sel), en));
    checkOutput({tag, "_n5"}, {23'd0, g5, i5, v5}, combExp(5, 0, req, int'(sel), en));
  endtask

  task automatic checkRegs(input string tag, input logic [7:0] r, input logic e, input logic [2:0] s);
    checkOutput({tag, "_q0"}, {23'd0, gq0, vq0}, regExp(8, 0, r, int'(s), e));
    checkOutput({tag, "_q1"}, {23'd0, gq1, vq1}, regExp(8, 1, r, int'(s), e));
    checkOutput({tag, "_q5"}, {26'd0, gq5, vq5}, regExp(5, 0, r, int'(s), e));
  endtask

  initial begin
    logic [7:0] rr;
    logic       ee;
    logic [2:0] ss;

    $display("[TB] start");
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0, 3'd0);
    checkOutput("rst_q0", {23'd0, gq0, vq0}, 32'd0);
    checkOutput("rst_q1", {23'd0, gq1, vq1}, 32'd0);

    // Combinational path keeps working under reset while registers stay cleared.
    applyStimulus(8'hff, 1'b1, 3'd2);
    @(posedge clock); #1;
    checkComb("rst_comb");
    checkRegs("rst_hold", 8'h00, 1'b0, 3'd0);

    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checkRegs("rst_release", 8'hff, 1'b1, 3'd2);

    applyStimulus(8'hb4, 1'b1, 3'd0);
    checkOutput("r025_d0", {24'd0, g0}, 32'h04);
    checkOutput("r025_i0", {29'd0, i0}, 32'd2);
    checkOutput("r025_d1", {24'd0, g1}, 32'h80);
    checkOutput("r025_i1", {29'd0, i1}, 32'd7);

    applyStimulus(8'h05, 1'b1, 3'd3);
    checkOutput("r026_d0", {24'd0, g0}, 32'h01);
    checkOutput("r026_d1", {24'd0, g1}, 32'h04);

    applyStimulus(8'hff, 1'b0, 3'd5);
    checkOutput("r027_en0_d0", {20'd0, g0, i0, v0}, 32'd0);
    checkOutput("r027_en0_d1", {20'd0, g1, i1, v1}, 32'd0);
    applyStimulus(8'h00, 1'b1, 3'd6);
    checkOutput("r027_req0_d0", {20'd0, g0, i0, v0}, 32'd0);
    checkOutput("r027_req0_d1", {20'd0, g1, i1, v1}, 32'd0);

    // sel values 5..7 must behave as sel=0 on the N=5 instance.
    applyStimulus(8'h12, 1'b1, 3'd6);
    checkOutput("n5_sel6", {27'd0, g5}, 32'h02);
    applyStimulus(8'h11, 1'b1, 3'd7);
    checkOutput("n5_sel7", {27'd0, g5}, 32'h01);

    for (int s = 0; s < 8; s++) begin
      for (int r = 0; r < 256; r++) begin
        applyStimulus(8'(r), 1'b1, 3'(s));
        checkComb("sweep");
      end
    end

    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      rr = 8'($urandom);
      ee = ($urandom_range(3) != 0);
      ss = 3'($urandom);
      applyStimulus(rr, ee, ss);
      checkComb("rand_comb");
      @(posedge clock); #1;
      checkRegs("rand_reg", rr, ee, ss);
    end

    @(negedge clock);
    applyStimulus(8'h30, 1'b1, 3'd0);
    @(posedge clock); #1;
    checkOutput("mid_valid_q", {31'd0, vq0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkRegs("mid_rst", 8'h00, 1'b0, 3'd0);
    checkComb("mid_rst_comb");
    @(posedge clock); #1;
    checkRegs("mid_rst_hold", 8'h00, 1'b0, 3'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(8'h48, 1'b1, 3'd4);
    @(posedge clock); #1;
    checkRegs("mid_release", 8'h48, 1'b1, 3'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pselect.md
PSELECT -- requirements
Module: pselect

Interface
REQ-001 Parameter N SHALL be declared: default 8; number of request/grant lines; legal range N >= 2.
REQ-002 Parameter DIR SHALL be declared: default 0; 0 = priority search runs toward higher indices, 1 = toward lower indices.
REQ-003 Port clock SHALL be: input, 1 bit; sole clock, rising-edge active.
REQ-004 Port reset SHALL be: input, 1 bit; asynchronous, active-low; clears all registered state.
REQ-005 Port req SHALL be: input, N bits; request vector, bit i = requester i.
REQ-006 Port en SHALL be: input, 1 bit; grant enable.
REQ-007 Port sel SHALL be: input, $clog2(N) bits; rotation offset selecting the highest-priority position.
REQ-008 Port gnt SHALL be: output, N bits; combinational one-hot-or-zero grant.
REQ-009 Port gnt_idx SHALL be: output, $clog2(N) bits; binary index of the set gnt bit, 0 when none.
REQ-010 Port gnt_valid SHALL be: output, 1 bit; high when gnt is nonzero.
REQ-011 Port gnt_q SHALL be: output, N bits; gnt registered on the rising clock edge.
REQ-012 Port gnt_valid_q SHALL be: output, 1 bit; gnt_valid registered on the rising clock edge.

Function
REQ-013 gnt, gnt_idx and gnt_valid SHALL be purely combinational functions of req, en and sel, with zero-cycle latency and no dependence on clock or reset.
REQ-014 gnt SHALL have at most one bit set.
REQ-015 When en=0 or req=0, gnt SHALL be all zeros, gnt_idx SHALL be 0 and gnt_valid SHALL be 0.
REQ-016 For DIR=0, the start position SHALL be p = sel; positions SHALL be searched p, p+1, ..., N-1, 0, ..., p-1, and the first set req bit SHALL be granted.
REQ-017 For DIR=1, the start position SHALL be p = (N-1-sel) mod N; positions SHALL be searched p, p-1, ..., 0, N-1, ..., p+1, and the first set req bit SHALL be granted.
REQ-018 With sel=0, DIR=0 SHALL grant the lowest-index set req bit, and DIR=1 SHALL grant the highest-index set req bit.
REQ-019 If N is not a power of two, sel values >= N SHALL be treated as sel=0.
REQ-020 Wrap-around SHALL be seamless: a request below the start position (DIR=0), or above it (DIR=1), SHALL be granted only when no request exists on the search path before the wrap.
REQ-021 gnt_q and gnt_valid_q SHALL capture gnt and gnt_valid on every rising clock edge while reset is high, with one-cycle latency and no enable gating beyond en's effect on gnt.

Reset
REQ-022 While reset=0, gnt_q SHALL be 0 and gnt_valid_q SHALL be 0, asynchronously and regardless of clock.
REQ-023 Assertion of reset SHALL NOT affect the combinational outputs gnt, gnt_idx or gnt_valid.
REQ-024 After reset deasserts, the first rising edge SHALL load the current gnt and gnt_valid.

Verification
REQ-025 With N=8, sel=0, en=1, req=10110100: DIR=0 SHALL give gnt=00000100 and gnt_idx=2; DIR=1 SHALL give gnt=10000000 and gnt_idx=7.
REQ-026 With N=8, en=1, sel=3, req=00000101: DIR=0 SHALL give gnt=00000001 (wrap); DIR=1 SHALL give gnt=00000100 (start position 4).
REQ-027 With en=0 and req=11111111 (any sel), or with en=1 and req=00000000, the block SHALL give gnt=0, gnt_idx=0 and gnt_valid=0.
REQ-028 For every sel in 0..7, an exhaustive sweep of all 256 req values SHALL produce gnt equal to the rotated priority model of REQ-016/017 in both DIR instances.
REQ-029 If req changes at a negedge, gnt SHALL update immediately and gnt_q SHALL equal that gnt after the next posedge.
REQ-030 If reset is driven low mid-stream with gnt_valid_q=1, gnt_q SHALL go to 0 and gnt_valid_q to 0 immediately, while gnt remains unchanged.
